// File: rtl/vga_txt_pkg.sv
// Shared geometry, widths and bus payload types for the text-mode pixel generator.
package vga_txt_pkg;

    localparam int unsigned COLS     = 80;
    localparam int unsigned ROWS     = 25;
    localparam int unsigned FONT_H   = 16;
    localparam int unsigned CHAR_W   = 8;
    localparam int unsigned PIPE_LAT = 8;

    localparam int unsigned TXT_AW  = 11;
    localparam int unsigned SL_W    = $clog2(FONT_H);
    localparam int unsigned FONT_AW = 8 + SL_W;
    localparam int unsigned COL_W   = $clog2(COLS + 1);
    localparam int unsigned ROW_W   = $clog2(ROWS + 1);
    localparam int unsigned Q_W     = $clog2(CHAR_W);

    // Font ROM address: character code in the upper bits, glyph scanline below.
    typedef struct packed {
        logic [7:0]      code;
        logic [SL_W-1:0] line;
    } font_addr_t;

endpackage

// File: rtl/vga_txt_pixgen_if.sv
// Video-enable, text RAM / font ROM fetch and pixel output bundle of the text pixel generator.
interface vga_txt_pixgen_if;
    import vga_txt_pkg::*;

    logic               i_en_h;
    logic               i_en_v;
    logic [TXT_AW-1:0]  o_txt_addr;
    logic [7:0]         i_txt_data;
    logic [FONT_AW-1:0] o_font_addr;
    logic [7:0]         i_font_data;
    logic               o_pix;
    logic               o_de;

    // master: timing generator, memories and colour stage surrounding the pixel generator
    modport master (
        output i_en_h, i_en_v, i_txt_data, i_font_data,
        input  o_txt_addr, o_font_addr, o_pix, o_de
    );

    modport slave (
        input  i_en_h, i_en_v, i_txt_data, i_font_data,
        output o_txt_addr, o_font_addr, o_pix, o_de
    );

endinterface

// File: rtl/vga_pix_shift8.sv
// Glyph-row serializer plus the matching data-enable delay line.
module vga_pix_shift8
    import vga_txt_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_act,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CHAR_W-1:0] i_data,
    output logic              o_pix,
    output logic              o_de
);

    logic [CHAR_W-1:0]   shifter;
    logic [PIPE_LAT-1:0] de_dly;

    // Shifting never stops, so a dropped line drains zeros rather than a stale glyph.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shifter <= '0;
            de_dly  <= '0;
        end else begin
            if (i_load) begin
                shifter <= i_clear ? '0 : i_data;
            end else begin
                shifter <= {shifter[CHAR_W-2:0], 1'b0};
            end
            de_dly <= {de_dly[PIPE_LAT-2:0], i_act};
        end
    end

    assign o_pix = shifter[CHAR_W-1];
    assign o_de  = de_dly[PIPE_LAT-1];

endmodule

// File: rtl/vga_txt_pixgen.sv
// Text-mode pixel generator: walks the character grid, fetches code and glyph row,
// and hands each glyph row to the serializer.
module vga_txt_pixgen
    import vga_txt_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst,
    vga_txt_pixgen_if.slave bus
);

    logic               act;
    logic               act_q;
    logic               line_end;
    logic               last_q;
    logic               blank;
    logic               load;
    logic [Q_W-1:0]     q;
    logic [COL_W-1:0]   col;
    logic [SL_W-1:0]    scanline;
    logic [ROW_W-1:0]   row;
    logic [TXT_AW-1:0]  row_base;
    logic [CHAR_W-1:0]  hold;
    logic               pix;
    logic               de;
    font_addr_t         font_addr;

    assign act      = bus.i_en_h & bus.i_en_v;
    assign last_q   = (q == Q_W'(CHAR_W - 1));
    assign line_end = act_q & ~act & bus.i_en_v;
    assign blank    = (col >= COL_W'(COLS)) || (row >= ROW_W'(ROWS));
    assign load     = act & last_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            act_q    <= 1'b0;
            q        <= '0;
            col      <= '0;
            scanline <= '0;
            row      <= '0;
            row_base <= '0;
            hold     <= '0;
        end else begin
            act_q <= act;
            q     <= act ? q + 1'b1 : '0;

            if (!act) begin
                col <= '0;
            end else if (last_q && (col < COL_W'(COLS))) begin
                col <= col + 1'b1;
            end

            // Glyph row arrives two cycles after the character's first pixel slot.
            if (act && (q == Q_W'(2))) begin
                hold <= bus.i_font_data;
            end

            // row_base stops at the last row so the text address never leaves the buffer.
            if (!bus.i_en_v) begin
                scanline <= '0;
                row      <= '0;
                row_base <= '0;
            end else if (line_end) begin
                if (scanline == SL_W'(FONT_H - 1)) begin
                    scanline <= '0;
                    if (row < ROW_W'(ROWS)) begin
                        row <= row + 1'b1;
                    end
                    if (row < ROW_W'(ROWS - 1)) begin
                        row_base <= row_base + TXT_AW'(COLS);
                    end
                end else begin
                    scanline <= scanline + 1'b1;
                end
            end
        end
    end

    assign bus.o_txt_addr  = blank ? '0 : row_base + TXT_AW'(col);
    assign font_addr       = '{code: bus.i_txt_data, line: scanline};
    assign bus.o_font_addr = font_addr;

    vga_pix_shift8 u_shift (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_act   (act),
        .i_load  (load),
        .i_clear (blank),
        .i_data  (hold),
        .o_pix   (pix),
        .o_de    (de)
    );

    assign bus.o_pix = pix;
    assign bus.o_de  = de;

endmodule

// File: tb/tb_vga_txt_pixgen.sv
// Self-checking bench for vga_txt_pixgen: memory models, per-cycle pixel scoreboard, scenario tasks.
module tb_vga_txt_pixgen;
    import vga_txt_pkg::*;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    vga_txt_pixgen_if bus ();

    vga_txt_pixgen dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0] txt_mem  [0:2047];
    logic [7:0] font_mem [0:4095];

    // Synchronous memories, one clock of read latency.
    always @(posedge i_clk) begin
        bus.i_txt_data  <= txt_mem[bus.o_txt_addr];
        bus.i_font_data <= font_mem[bus.o_font_addr];
    end

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        int   cyc;
        logic de;
        logic pix;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   mon_en   = 1'b0;
    int   ln       = 0;

    function automatic int cur_row();
        int r;
        r = ln / int'(FONT_H);
        if (r > int'(ROWS)) r = int'(ROWS);
        return r;
    endfunction

    // Pixel at offset k of a line whose act lasted len clocks.
    function automatic logic exp_pix(int k, int len);
        int n;
        int r;
        logic [7:0] code;
        logic [7:0] g;
        n = k / 8;
        r = cur_row();
        if (n >= len / 8 || n >= int'(COLS) || r >= int'(ROWS)) return 1'b0;
        code = txt_mem[r * int'(COLS) + n];
        g    = font_mem[{code, SL_W'(ln % int'(FONT_H))}];
        return g[7 - (k % 8)];
    endfunction

    // Scoreboard monitor: every cycle pop the expectation for this cycle (idle = 0/0).
    always @(negedge i_clk) begin
        if (mon_en) begin
            mon_e.cyc = cyc;
            mon_e.de  = 1'b0;
            mon_e.pix = 1'b0;
            if (sb.size() > 0 && sb[0].cyc == cyc) mon_e = sb.pop_front();
            n_checks++;
            if ({bus.o_de, bus.o_pix} !== {mon_e.de, mon_e.pix})
                $display("FAIL stream cyc=%0d de,pix got %b%b expected %b%b",
                         cyc, bus.o_de, bus.o_pix, mon_e.de, mon_e.pix);
            else
                n_pass++;
            n_checks++;
            if (int'(bus.o_txt_addr) > int'(COLS * ROWS) - 1)
                $display("FAIL txt_addr_range cyc=%0d got %0d expected <= %0d",
                         cyc, bus.o_txt_addr, COLS * ROWS - 1);
            else
                n_pass++;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push_exp(int k, int len);
        exp_t e;
        e.cyc = cyc + int'(PIPE_LAT);
        e.de  = 1'b1;
        e.pix = exp_pix(k, len);
        sb.push_back(e);
    endtask

    task automatic start_frame();
        bus.i_en_h = 1'b0;
        bus.i_en_v = 1'b0;
        repeat (4) tick();
        ln = 0;
        bus.i_en_v = 1'b1;
        repeat (2) tick();
    endtask

    task automatic drive_line(int len, int gap);
        int r;
        r = cur_row();
        for (int k = 0; k < len; k++) begin
            tick();
            bus.i_en_h = 1'b1;
            push_exp(k, len);
            if (k == 0 && r < int'(ROWS)) begin
                n_checks++;
                if (int'(bus.o_txt_addr) !== r * int'(COLS))
                    $display("FAIL txt_addr_line%0d got %0d expected %0d", ln, bus.o_txt_addr, r * int'(COLS));
                else
                    n_pass++;
            end
            if (k == 1 && r < int'(ROWS)) begin
                n_checks++;
                if (bus.o_font_addr !== {txt_mem[r * int'(COLS)], SL_W'(ln % int'(FONT_H))})
                    $display("FAIL font_addr_line%0d got %h expected %h", ln, bus.o_font_addr,
                             {txt_mem[r * int'(COLS)], SL_W'(ln % int'(FONT_H))});
                else
                    n_pass++;
            end
        end
        tick();
        bus.i_en_h = 1'b0;
        repeat (gap - 1) tick();
        ln++;
    endtask

    task automatic fill_solid();
        for (int a = 0; a < 2048; a++) txt_mem[a] = 8'h01;
        for (int a = 0; a < 4096; a++) font_mem[a] = 8'hFF;
    endtask

    task automatic test_reset();
        for (int a = 0; a < 2048; a++) txt_mem[a] = 8'h20;
        for (int a = 0; a < 4096; a++) font_mem[a] = 8'(a * 29 + 5);
        bus.i_en_h = 1'b0;
        bus.i_en_v = 1'b0;
        i_rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (bus.o_pix !== 1'b0) $display("FAIL reset_pix got %b expected 0", bus.o_pix); else n_pass++;
        n_checks++;
        if (bus.o_de !== 1'b0) $display("FAIL reset_de got %b expected 0", bus.o_de); else n_pass++;
        n_checks++;
        if (bus.o_txt_addr !== '0) $display("FAIL reset_txt_addr got %0d expected 0", bus.o_txt_addr); else n_pass++;
        i_rst = 1'b0;
        tick();
        mon_en = 1'b1;
    endtask

    task automatic test_first_line();
        logic [7:0] pat;
        pat = 8'hA5;
        txt_mem[0] = 8'h41;
        txt_mem[1] = 8'h41;
        font_mem[12'h410] = pat;
        start_frame();
        for (int k = 0; k < 16; k++) begin
            tick();
            bus.i_en_h = 1'b1;
            push_exp(k, 16);
            if (k == 0) begin
                n_checks++;
                if (bus.o_txt_addr !== '0) $display("FAIL first_txt_addr got %0d expected 0", bus.o_txt_addr); else n_pass++;
            end
            if (k == 1) begin
                n_checks++;
                if (bus.o_font_addr !== 12'h410) $display("FAIL first_font_addr got %h expected 410", bus.o_font_addr); else n_pass++;
            end
            if (k == 7) begin
                n_checks++;
                if (bus.o_de !== 1'b0) $display("FAIL first_de_early got %b expected 0", bus.o_de); else n_pass++;
            end
            if (k >= 8) begin
                n_checks++;
                if (bus.o_pix !== pat[15 - k] || bus.o_de !== 1'b1)
                    $display("FAIL first_pix clk%0d got pix=%b de=%b expected pix=%b de=1", k, bus.o_pix, bus.o_de, pat[15 - k]);
                else
                    n_pass++;
            end
        end
        tick();
        bus.i_en_h = 1'b0;
        repeat (15) tick();
        ln++;
    endtask

    task automatic test_full_line();
        int de_cnt;
        int pix_cnt;
        int fall_k;
        logic prev_de;
        for (int a = 0; a < 2048; a++) txt_mem[a] = 8'h01;
        txt_mem[79] = 8'h00;
        for (int a = 0; a < 4096; a++) font_mem[a] = (a < int'(FONT_H)) ? 8'h00 : 8'hFF;
        start_frame();
        de_cnt = 0; pix_cnt = 0; fall_k = -1; prev_de = 1'b0;
        for (int k = 0; k < 660; k++) begin
            tick();
            bus.i_en_h = (k < 640);
            if (k < 640) push_exp(k, 640);
            if (bus.o_de === 1'b1) de_cnt++;
            if (bus.o_pix === 1'b1) pix_cnt++;
            if (prev_de === 1'b1 && bus.o_de === 1'b0 && fall_k < 0) fall_k = k;
            prev_de = bus.o_de;
        end
        ln++;
        n_checks++;
        if (de_cnt !== 640) $display("FAIL full_de_count got %0d expected 640", de_cnt); else n_pass++;
        n_checks++;
        if (pix_cnt !== 632) $display("FAIL full_pix_count got %0d expected 632", pix_cnt); else n_pass++;
        n_checks++;
        if (fall_k !== 648) $display("FAIL full_de_fall got clk%0d expected clk648", fall_k); else n_pass++;
    endtask

    task automatic test_partial_char();
        fill_solid();
        start_frame();
        drive_line(43, 12);
        drive_line(24, 12);
    endtask

    task automatic test_sixteen_lines();
        for (int a = 0; a < 2048; a++) txt_mem[a] = 8'(a * 7 + 3);
        for (int a = 0; a < 4096; a++) font_mem[a] = 8'(a * 29 + 5);
        start_frame();
        for (int l = 0; l < 17; l++) drive_line(24, 6);
    endtask

    task automatic test_row_saturation();
        fill_solid();
        start_frame();
        for (int l = 0; l < 401; l++) drive_line(16, 4);
    endtask

    task automatic test_mid_reset();
        fill_solid();
        start_frame();
        for (int k = 0; k < 20; k++) begin
            tick();
            bus.i_en_h = 1'b1;
            push_exp(k, 640);
        end
        tick();
        i_rst = 1'b1;
        sb.delete();
        #1;
        n_checks++;
        if (bus.o_pix !== 1'b0) $display("FAIL midreset_pix got %b expected 0", bus.o_pix); else n_pass++;
        n_checks++;
        if (bus.o_de !== 1'b0) $display("FAIL midreset_de got %b expected 0", bus.o_de); else n_pass++;
        bus.i_en_h = 1'b0;
        bus.i_en_v = 1'b0;
        repeat (3) tick();
        i_rst = 1'b0;
        start_frame();
        drive_line(24, 12);
    endtask

    initial begin
        bus.i_en_h = 1'b0;
        bus.i_en_v = 1'b0;
        test_reset();
        test_first_line();
        test_full_line();
        test_partial_char();
        test_sixteen_lines();
        test_row_saturation();
        test_mid_reset();
        repeat (20) tick();
        n_checks++;
        if (sb.size() !== 0) $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size()); else n_pass++;
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_txt_pixgen.md
Name: vga_txt_pixgen

Overview:
Text-mode pixel generator and the consumer end of the 8-pixel character-column tick. It walks the 80x25 character grid in step with the horizontal and vertical active-video enables. Per character it reads the code from text RAM and the glyph row from font ROM (both synchronous, 1-cycle latency). It serializes the 8 glyph bits to a 1-bit pixel stream with a matching delayed data-enable. It sits between the VGA timing generator and the output DAC/colour stage.

Parameters:
COLS, 80, characters per text row
ROWS, 25, text rows per frame
FONT_H, 16, scanlines per glyph (power of 2)
TXT_AW, 11, text RAM address width (must hold COLS*ROWS-1)
FONT_AW, 12, font ROM address width (8 + log2(FONT_H))

Ports:
i_clk  in  1  pixel clock
i_rst  in  1  asynchronous active-high reset
i_en_h  in  1  horizontal active-video enable
i_en_v  in  1  vertical active-video enable
o_txt_addr  out  TXT_AW  text RAM read address
i_txt_data  in  8  character code, valid 1 clk after o_txt_addr
o_font_addr  out  FONT_AW  font ROM address = {code, scanline}
i_font_data  in  8  glyph row, MSB = leftmost pixel, valid 1 clk after o_font_addr
o_pix  out  1  pixel (1 = foreground)
o_de  out  1  pixel-valid; i_en_h AND i_en_v delayed 8 clk

Behaviour:
- Reset (async, i_rst=1): all outputs and state 0. Covers o_pix, o_de, addresses, column phase q, column, scanline, row, row base, glyph hold, shifter and de delay line. Reset mid-line aborts the fetch; the first post-reset char starts cleanly at the next active line.
- act = i_en_h & i_en_v. 3-bit phase q counts 0..7 while act and wraps 7->0. q=0 whenever act=0, including a drop mid-character.
- Column col increments when q==7 while act; col=0 when act=0.
- Fetch pipeline for char n, cycles relative to its q=0:
  - q=0: o_txt_addr = row_base + col (registered out the same cycle, combinational from counters is acceptable if stable).
  - q=1: o_font_addr = {i_txt_data, scanline}.
  - q=2: glyph hold <= i_font_data.
  - q==7 edge: shifter <= hold, or 0 if col>=COLS or row>=ROWS (blank). Otherwise the shifter shifts left, filling 0.
- o_pix = shifter MSB. Char 0 pixels appear 8 clk after first act. Total act->pixel latency is exactly 8 clk.
- o_de: 8-stage delay of act. The shifter keeps shifting while o_de=1 after act falls, so the last char flushes fully.
- Partial last char (act falls at q<7): that char is never loaded. Its o_de cycles show the previous char's shifted-out 0s. This is required: no stale glyph is repeated.
- Scanline/row advance on the act falling edge (line end, i_en_v=1):
  - scanline+1.
  - At FONT_H-1: scanline=0, row+1, row_base += COLS.
  - row saturates at ROWS. Rows past ROWS give blank pixels and do not advance o_txt_addr.
- Frame: while i_en_v=0, scanline=0, row=0, row_base=0.
- Address arithmetic: row_base is an incremental add, with no multiplier. o_txt_addr is held below COLS*ROWS by the blanking rules.
- Timing generator must delay hsync/vsync by 8 clk to align with o_de.

Decomposition:
- Shared package vga_txt_pkg: COLS, ROWS, FONT_H, CHAR_W=8, PIPE_LAT=8, derived address widths.
- One natural sub-module: vga_pix_shift8. It holds the 8-bit shifter plus the 8-stage de delay line, with load/shift/clear controls. Counters and fetch sequencing stay in the top.

Test Plan:
- Reset then one active line, text RAM char0=0x41, font ROM row 0 of 0x41=0xA5:
  - o_txt_addr=0 at q=0; o_font_addr=0x410 at q=1.
  - o_pix = 1,0,1,0,0,1,0,1 on clk 8..15; o_de rises on clk 8.
- Full 640-clk line, font all 0xFF except col 79 = 0x00: o_de high 640 clk; o_pix high 632 clk then low 8; o_de falls 8 clk after act.
- 16 lines: on line 16, o_txt_addr at col 0 is 80 and scanline field of o_font_addr is 0. On line 15 the scanline field = 15.
- act dropped at q=3 of col 5: col 4 pixels emitted completely; col 5 never loaded (o_pix=0 during its slots); next line starts with q=0, col=0.
- 401 active lines (row>=25 region): pixels of line 401 all 0, o_de still follows act. o_txt_addr never exceeds 1999.
- i_rst asserted mid-line at q=4: o_pix=0 and o_de=0 immediately (async). After release, the next active line output matches a clean start.
